// File: rtl/rv_mem_arb.sv
// Shares one memory bus between the instruction-fetch port and the data load/store port.
// Each transfer is granted from IDLE, held on the bus until ack or timeout, then completed with a pulse.
module rv_mem_arb #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int TIMEOUT    = 255,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req_i,
    input  logic [AW-1:0]   if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [DW-1:0]   if_rdata_o,
    output logic            if_err_o,
    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic [AW-1:0]   d_addr_i,
    input  logic [DW-1:0]   d_wdata_i,
    input  logic [DW/8-1:0] d_be_i,
    output logic            d_gnt_o,
    output logic            d_rvalid_o,
    output logic [DW-1:0]   d_rdata_o,
    output logic            d_err_o,
    output logic            m_req_o,
    output logic            m_we_o,
    output logic [AW-1:0]   m_addr_o,
    output logic [DW-1:0]   m_wdata_o,
    output logic [DW/8-1:0] m_be_o,
    input  logic            m_ack_i,
    input  logic [DW-1:0]   m_rdata_i,
    output logic            busy_o
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [15:0]   WAIT_LAST  = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, IF_WAIT, D_WAIT} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] starve_cnt;
    logic [15:0]   wait_cnt;
    logic          ack_done, timeout_done, xfer_done;

    assign busy_o       = (state != IDLE);
    assign ack_done     = busy_o && m_ack_i;
    assign timeout_done = busy_o && !m_ack_i && (wait_cnt == WAIT_LAST);
    assign xfer_done    = ack_done || timeout_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Fetch only beats a pending data request once it has lost STARVE_MAX times in a row.
    always_comb begin
        state_nxt = state;
        if_gnt_o  = 1'b0;
        d_gnt_o   = 1'b0;
        case (state)
            IDLE: begin
                if (if_req_i && (!d_req_i || starve_cnt == STARVE_LIM)) begin
                    if_gnt_o  = 1'b1;
                    state_nxt = IF_WAIT;
                end else if (d_req_i) begin
                    d_gnt_o   = 1'b1;
                    state_nxt = D_WAIT;
                end
            end
            IF_WAIT, D_WAIT: begin
                if (xfer_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (if_gnt_o || !if_req_i)
                starve_cnt <= '0;
            else if (d_gnt_o && starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_req_o     <= 1'b0;
            m_we_o      <= 1'b0;
            m_addr_o    <= '0;
            m_wdata_o   <= '0;
            m_be_o      <= '0;
            wait_cnt    <= '0;
            if_rvalid_o <= 1'b0;
            if_rdata_o  <= '0;
            if_err_o    <= 1'b0;
            d_rvalid_o  <= 1'b0;
            d_rdata_o   <= '0;
            d_err_o     <= 1'b0;
        end else begin
            if_rvalid_o <= 1'b0;
            if_err_o    <= 1'b0;
            d_rvalid_o  <= 1'b0;
            d_err_o     <= 1'b0;
            if (if_gnt_o) begin
                m_req_o   <= 1'b1;
                m_we_o    <= 1'b0;
                m_addr_o  <= if_addr_i;
                m_wdata_o <= '0;
                m_be_o    <= '1;
                wait_cnt  <= '0;
            end else if (d_gnt_o) begin
                m_req_o   <= 1'b1;
                m_we_o    <= d_we_i;
                m_addr_o  <= d_addr_i;
                m_wdata_o <= d_we_i ? d_wdata_i : '0;
                m_be_o    <= d_we_i ? d_be_i : '1;
                wait_cnt  <= '0;
            end else if (xfer_done) begin
                m_req_o <= 1'b0;
                if (state == IF_WAIT) begin
                    if_rvalid_o <= 1'b1;
                    if_err_o    <= timeout_done;
                    if_rdata_o  <= ack_done ? m_rdata_i : '0;
                end else begin
                    d_rvalid_o <= 1'b1;
                    d_err_o    <= timeout_done;
                    d_rdata_o  <= (ack_done && !m_we_o) ? m_rdata_i : '0;
                end
            end else if (busy_o) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end
    end
endmodule
